// File: rtl/fft_fsm.sv
// fft_fsm: Moore control sequencer for an in-place radix-2 FFT datapath.
module fft_fsm (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  input  logic       end_samples_i,
  input  logic       end_read_1,
  input  logic       end_read_2,
  input  logic       end_compute_i,
  input  logic       end_write_1,
  input  logic       end_algo_i,
  output logic       en_cnt_samples_o,
  output logic       wr_mem_o,
  output logic       en_cnt_rd_o,
  output logic       done_o,
  output logic [2:0] state_o
);
  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] SAMPLE  = 3'd1;
  localparam logic [2:0] READ1   = 3'd2;
  localparam logic [2:0] READ2   = 3'd3;
  localparam logic [2:0] COMPUTE = 3'd4;
  localparam logic [2:0] WRITE1  = 3'd5;
  localparam logic [2:0] WRITE2  = 3'd6;
  localparam logic [2:0] DONE    = 3'd7;
  logic [2:0] state, nxt;
  always_comb begin
    nxt = IDLE;
    case (state)
      IDLE:    nxt = start_i ? SAMPLE : IDLE;
      SAMPLE:  nxt = end_samples_i ? READ1 : SAMPLE;
      READ1:   nxt = end_read_1 ? READ2 : READ1;
      READ2:   nxt = end_read_2 ? COMPUTE : READ2;
      COMPUTE: nxt = end_compute_i ? WRITE1 : COMPUTE;
      WRITE1:  nxt = end_write_1 ? WRITE2 : WRITE1;
      WRITE2:  nxt = end_algo_i ? DONE : READ1;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk_i) state <= rst_i ? IDLE : nxt;
  assign state_o          = state;
  assign en_cnt_samples_o = state == SAMPLE;
  assign wr_mem_o         = state == SAMPLE || state == WRITE1 || state == WRITE2;
  assign en_cnt_rd_o      = state == READ1 || state == READ2;
  assign done_o           = state == DONE;
endmodule

// File: tb/tb_fft_fsm.sv
// tb_fft_fsm: table-driven scoreboard bench for the FFT control sequencer.
module tb_fft_fsm;
  logic clk = 0;
  logic rst_i = 0, start_i = 0, end_samples_i = 0, end_read_1 = 0, end_read_2 = 0;
  logic end_compute_i = 0, end_write_1 = 0, end_algo_i = 0;
  logic en_cnt_samples_o, wr_mem_o, en_cnt_rd_o, done_o;
  logic [2:0] state_o;
  int total = 0, bad = 0, done_seen = 0, done_exp = 0;
  localparam logic [7:0] R = 8'h80, S = 8'h40, ES = 8'h20, R1 = 8'h10;
  localparam logic [7:0] R2 = 8'h08, C = 8'h04, W1 = 8'h02, A = 8'h01, N = 8'h00;
  typedef struct { logic [7:0] in; logic [2:0] st; } vec_t;
  vec_t vecs[$];
  logic [2:0] sb[$];
  always #5 clk = ~clk;
  fft_fsm dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .end_samples_i(end_samples_i),
    .end_read_1(end_read_1), .end_read_2(end_read_2), .end_compute_i(end_compute_i),
    .end_write_1(end_write_1), .end_algo_i(end_algo_i),
    .en_cnt_samples_o(en_cnt_samples_o), .wr_mem_o(wr_mem_o), .en_cnt_rd_o(en_cnt_rd_o),
    .done_o(done_o), .state_o(state_o)
  );
  task automatic add(input logic [7:0] in, input logic [2:0] st, input int rep = 1);
    for (int i = 0; i < rep; i++) vecs.push_back('{in, st});
  endtask
  task automatic check(input string name, input int idx, input logic [3:0] act, input logic [3:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s vec=%0d got=%0h want=%0h", name, idx, act, exp);
    end
  endtask
  initial begin
    logic [2:0] e;
    logic [3:0] eo;
    add(R | S, 0);
    add(N, 0, 3);
    add(S, 1); add(ES, 2); add(R1, 3); add(R2, 4); add(C, 5); add(W1, 6); add(A, 7); add(N, 0);
    add(S, 1); add(ES, 2); add(R1, 3); add(R2, 4); add(C, 5); add(W1, 6); add(N, 2);
    add(R1, 3); add(R2, 4); add(C, 5); add(W1, 6); add(A, 7); add(N, 0);
    add(S, 1); add(N, 1, 5); add(R1 | R2 | C | W1 | A, 1); add(ES, 2);
    add(N, 2, 5); add(C | R2 | W1 | A | ES, 2); add(R1, 3);
    add(N, 3, 5); add(R1 | C | W1, 3); add(R2, 4);
    add(N, 4, 5); add(R2 | W1 | A, 4); add(C, 5);
    add(N, 5, 5); add(C | A, 5); add(W1, 6); add(A, 7); add(N, 0);
    add(S, 1); add(ES, 2); add(R1, 3); add(R2, 4); add(R | C, 0); add(N, 0); add(S, 1);
    add(ES, 2); add(R1, 3); add(R2, 4); add(C, 5); add(W1, 6); add(A, 7); add(N, 0);
    add(S, 1); add(S | ES, 2); add(S | R1, 3); add(S | R2, 4); add(S | C, 5);
    add(S | W1, 6); add(S | A, 7); add(S, 0); add(S, 1); add(S | ES, 2);
    add(S | R | W1, 0);
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      {rst_i, start_i, end_samples_i, end_read_1, end_read_2, end_compute_i, end_write_1, end_algo_i} = vecs[i].in;
      sb.push_back(vecs[i].st);
      if (vecs[i].st == 3'd7) done_exp++;
      @(posedge clk);
      #1;
      e = sb.pop_front();
      eo = {e == 3'd1, e == 3'd1 || e == 3'd5 || e == 3'd6, e == 3'd2 || e == 3'd3, e == 3'd7};
      if (done_o) done_seen++;
      check("state", i, {1'b0, state_o}, {1'b0, e});
      check("outs", i, {en_cnt_samples_o, wr_mem_o, en_cnt_rd_o, done_o}, eo);
    end
    check("done_pulses", -1, done_seen[3:0], done_exp[3:0]);
    check("sb_empty", -1, sb.size() == 0 ? 4'd0 : 4'd1, 4'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fft_fsm.md
FFT_FSM -- requirements
Module: fft_fsm

Interface
REQ-001 SHALL have ports: clk_i  in  1  single clock; all state changes on its rising edge.
REQ-002 SHALL have ports: rst_i  in  1  reset, synchronous, active-high.
REQ-003 SHALL have ports: start_i  in  1  begin a new FFT run (sampled in IDLE only).
REQ-004 SHALL have ports: end_samples_i  in  1  sample counter reached last sample.
REQ-005 SHALL have ports: end_read_1  in  1  first operand read complete.
REQ-006 SHALL have ports: end_read_2  in  1  second operand read complete.
REQ-007 SHALL have ports: end_compute_i  in  1  butterfly computation complete.
REQ-008 SHALL have ports: end_write_1  in  1  first result write complete.
REQ-009 SHALL have ports: end_algo_i  in  1  all stages/butterflies processed.
REQ-010 SHALL have ports: en_cnt_samples_o  out  1  enable sample counter.
REQ-011 SHALL have ports: wr_mem_o  out  1  data-memory write enable.
REQ-012 SHALL have ports: en_cnt_rd_o  out  1  enable read-address counter.
REQ-013 SHALL have ports: done_o  out  1  run finished pulse.
REQ-014 SHALL have ports: state_o  out  3  current state, type state_fsm.

Function
REQ-015 SHALL define state_fsm as a 3-bit enum: IDLE=0, SAMPLE=1, READ1=2, READ2=3, COMPUTE=4, WRITE1=5, WRITE2=6, DONE=7.
REQ-016 SHALL be a Moore machine: all outputs decode from the registered state only; state_o equals the state register.
REQ-017 SHALL transition IDLE->SAMPLE when start_i=1, else stay in IDLE.
REQ-018 SHALL transition SAMPLE->READ1 when end_samples_i=1, else stay in SAMPLE.
REQ-019 SHALL transition READ1->READ2 when end_read_1=1, else stay in READ1.
REQ-020 SHALL transition READ2->COMPUTE when end_read_2=1, else stay in READ2.
REQ-021 SHALL transition COMPUTE->WRITE1 when end_compute_i=1, else stay in COMPUTE.
REQ-022 SHALL transition WRITE1->WRITE2 when end_write_1=1, else stay in WRITE1.
REQ-023 SHALL leave WRITE2 unconditionally after one cycle: to DONE if end_algo_i=1, else to READ1.
REQ-024 SHALL leave DONE unconditionally after one cycle to IDLE; start_i in DONE is ignored.
REQ-025 SHALL ignore every end_* input outside the state that consumes it; start_i is ignored outside IDLE.
REQ-026 SHALL drive en_cnt_samples_o=1 only in SAMPLE.
REQ-027 SHALL drive wr_mem_o=1 in SAMPLE, WRITE1 and WRITE2; 0 elsewhere.
REQ-028 SHALL drive en_cnt_rd_o=1 in READ1 and READ2; 0 elsewhere.
REQ-029 SHALL drive done_o=1 only in DONE, a single-cycle pulse per run.
REQ-030 SHALL have a 1-cycle latency from a qualifying input at a rising edge to the new state and outputs.
REQ-031 SHALL make unused encodings impossible; a defensive default branch returns to IDLE with all outputs 0.

Reset
REQ-032 SHALL, when rst_i=1 at a rising edge, set state to IDLE regardless of other inputs, including mid-run; reset has priority over all transitions.
REQ-033 SHALL hold outputs after reset at: state_o=IDLE(0), en_cnt_samples_o=0, wr_mem_o=0, en_cnt_rd_o=0, done_o=0.

Verification
REQ-034 SHALL verify reset: rst_i=1 for 1 cycle with start_i=1 -> state_o=0, all outputs 0; after release, no state change without start_i.
REQ-035 SHALL verify the full single-pass run: start_i pulse, then each end_* pulsed one cycle in order with end_algo_i=1 -> state sequence 0,1,2,3,4,5,6,7,0; done_o high exactly one cycle; wr_mem_o high in states 1,5,6.
REQ-036 SHALL verify the loop: end_algo_i=0 in WRITE2 -> next state READ1(2), en_cnt_rd_o=1; a second pass with end_algo_i=1 -> DONE then IDLE.
REQ-037 SHALL verify holds: each end_* held 0 for 5 cycles in its state -> state unchanged and outputs stable; out-of-order pulses (e.g. end_compute_i in READ1) -> no transition.
REQ-038 SHALL verify reset mid-operation: rst_i=1 while in COMPUTE -> IDLE next cycle, all outputs 0, and a new start_i restarts at SAMPLE.
REQ-039 SHALL verify start_i ignored in DONE and SAMPLE: start_i held 1 throughout a run -> exactly one DONE pulse per run, then immediate restart from IDLE->SAMPLE.
